// File: rtl/count_pwm.sv
`default_nettype none
// ============================================================================
// Module      : count_pwm
// Description : PWM generator slaved to an external free-running mod-16
//               counter. Detects the 15->0 wrap of the incoming count, emits a
//               one-cycle wrap pulse, counts completed periods, and applies a
//               new duty value (accepted via valid/ready handshake) only at a
//               period boundary so every PWM period is glitch-free.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PERIOD_W    width of the completed-period counter (default 8)
// Ports
//   clk         in   rising-edge clock, shared with the upstream counter
//   reset       in   asynchronous active-low reset
//   count       in   [3:0] count value from the upstream mod-16 counter
//   duty_in     in   [3:0] requested duty (high for duty_in of 16 counts)
//   duty_valid  in   duty_in is valid this cycle
//   duty_ready  out  block can accept duty_in this cycle
//   pwm_out     out  registered PWM output
//   wrap        out  one-cycle pulse at the start of a period
//   period_cnt  out  [PERIOD_W-1:0] completed periods, modulo 2^PERIOD_W
//   count_err   out  sticky flag, count did not advance by +1 mod 16
// Build option
//   COUNT_PWM_CHECK_EN  when defined, the count sequence checker drives
//                       count_err; otherwise count_err is tied low.
// ============================================================================
module count_pwm #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          count,
  input  logic [3:0]          duty_in,
  input  logic                duty_valid,
  output logic                duty_ready,
  output logic                pwm_out,
  output logic                wrap,
  output logic [PERIOD_W-1:0] period_cnt,
  output logic                count_err
);

  // Sampled copy of the incoming count and its validity.
  logic [3:0]          prev_count_q;
  logic                prev_vld_q;

  // Duty pipeline: pending holds an accepted value until the next wrap.
  logic [3:0]          active_q,       active_d;
  logic [3:0]          pending_q,      pending_d;
  logic                pending_full_q, pending_full_d;

  logic                pwm_q,          pwm_d;
  logic                wrap_q;
  logic [PERIOD_W-1:0] period_q,       period_d;

  logic                wrap_edge;
  logic                xfer;
  logic [3:0]          duty_eff;

  always_comb begin
    // A wrap is only recognised once a real previous sample exists, so the
    // first count seen after reset can never fake a 15->0 transition.
    wrap_edge = prev_vld_q && (prev_count_q == 4'hF) && (count == 4'h0);
    xfer      = duty_valid && !pending_full_q;

    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    period_d       = period_q;

    if (wrap_edge) begin
      period_d = period_q + PERIOD_W'(1);
      if (pending_full_q) begin
        active_d       = pending_q;
        pending_full_d = 1'b0;
      end
    end

    // ready is low whenever pending is occupied, so a transfer and a
    // pending-to-active load can never collide. A transfer on an empty-
    // pending wrap edge is simply queued for the following wrap.
    if (xfer) begin
      pending_d      = duty_in;
      pending_full_d = 1'b1;
    end

    // The first count of a new period must already use the new duty.
    duty_eff = (wrap_edge && pending_full_q) ? pending_q : active_q;
    pwm_d    = (count < duty_eff);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_count_q   <= 4'h0;
      prev_vld_q     <= 1'b0;
      active_q       <= 4'h0;
      pending_q      <= 4'h0;
      pending_full_q <= 1'b0;
      pwm_q          <= 1'b0;
      wrap_q         <= 1'b0;
      period_q       <= '0;
    end else begin
      prev_count_q   <= count;
      prev_vld_q     <= 1'b1;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      pwm_q          <= pwm_d;
      wrap_q         <= wrap_edge;
      period_q       <= period_d;
    end
  end

  assign duty_ready = !pending_full_q;
  assign pwm_out    = pwm_q;
  assign wrap       = wrap_q;
  assign period_cnt = period_q;

`ifdef COUNT_PWM_CHECK_EN
  logic [3:0] count_inc;
  logic       err_q;

  assign count_inc = prev_count_q + 4'd1;

  // Sticky: once a bad step is seen only reset clears the flag. A held
  // count is also a bad step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (prev_vld_q && (count != count_inc)) begin
      err_q <= 1'b1;
    end
  end

  assign count_err = err_q;
`else
  assign count_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_count_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_pwm
// Description : Directed self-checking bench for count_pwm (PERIOD_W = 2).
//               The bench drives the count input itself, one value per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_pwm;

  localparam int PERIOD_W = 2;

`ifdef COUNT_PWM_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                clk;
  logic                reset;
  logic [3:0]          count_r;
  logic [3:0]          duty_in;
  logic                duty_valid;
  logic                duty_ready;
  logic                pwm_out;
  logic                wrap;
  logic [PERIOD_W-1:0] period_cnt;
  logic                count_err;

  int checks;
  int errors;

  count_pwm #(.PERIOD_W(PERIOD_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count_r),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .wrap       (wrap),
    .period_cnt (period_cnt),
    .count_err  (count_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [3:0] c);
    count_r = c;
    cyc();
  endtask

  // Drives counts 0..15; duty_valid is high for indices vs..ve, duty_in is
  // da before index sw and db from sw on. Outputs are summarised per period.
  task automatic run_period(input int vs, input int ve,
                            input logic [3:0] da, input logic [3:0] db, input int sw,
                            output int highs, output int wraps, output int rdy_low,
                            output logic w0, output logic [PERIOD_W-1:0] pc0);
    highs = 0; wraps = 0; rdy_low = 0; w0 = 1'b0; pc0 = '0;
    for (int i = 0; i < 16; i++) begin
      count_r    = 4'(i);
      duty_valid = (i >= vs) && (i <= ve);
      duty_in    = (i >= sw) ? db : da;
      cyc();
      highs   += int'(pwm_out);
      wraps   += int'(wrap);
      rdy_low += int'(!duty_ready);
      if (i == 0) begin
        w0  = wrap;
        pc0 = period_cnt;
      end
    end
    duty_valid = 1'b0;
  endtask

  int               h, wr, rl;
  logic             w0;
  logic [PERIOD_W-1:0] pc;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; count_r = 4'h0; duty_in = 4'h0; duty_valid = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b0;
    #1;
    check("rst_pwm",    pwm_out,    0);
    check("rst_wrap",   wrap,       0);
    check("rst_pcnt",   period_cnt, 0);
    check("rst_err",    count_err,  0);
    check("rst_ready",  duty_ready, 1);
    cyc(); cyc();
    reset = 1'b1;

    // First period after release: first sample must not wrap or flag.
    run_period(-1, -2, 4'h0, 4'h0, 0, h, wr, rl, w0, pc);
    check("p0_wraps", wr, 0);
    check("p0_highs", h, 0);
    check("p0_err",   count_err, 0);

    // P1: no duty written.
    run_period(-1, -2, 4'h0, 4'h0, 0, h, wr, rl, w0, pc);
    check("p1_w0",    w0, 1);
    check("p1_wraps", wr, 1);
    check("p1_pc",    pc, 1);
    check("p1_highs", h, 0);

    // P2: duty 4 written mid-period at count 6.
    run_period(6, 6, 4'h4, 4'h4, 0, h, wr, rl, w0, pc);
    check("p2_pc",    pc, 2);
    check("p2_highs", h, 0);
    check("p2_rdylo", rl, 10);

    // P3: duty 4 applies, ready back high from the wrap.
    run_period(-1, -2, 4'h0, 4'h0, 0, h, wr, rl, w0, pc);
    check("p3_pc",    pc, 3);
    check("p3_highs", h, 4);
    check("p3_rdylo", rl, 0);

    // P4: transfer duty 15 on the wrap edge; old duty kept; counter rolls 3->0.
    run_period(0, 0, 4'hF, 4'hF, 0, h, wr, rl, w0, pc);
    check("p4_pc",    pc, 0);
    check("p4_highs", h, 4);
    check("p4_rdylo", rl, 16);

    // P5: duty 15 applies.
    run_period(-1, -2, 4'h0, 4'h0, 0, h, wr, rl, w0, pc);
    check("p5_pc",    pc, 1);
    check("p5_highs", h, 15);
    check("p5_rdylo", rl, 0);

    // P6/P7: valid held, 9 then 12; only 9 accepted while pending is full.
    run_period(2, 15, 4'h9, 4'hC, 3, h, wr, rl, w0, pc);
    check("p6_pc",    pc, 2);
    check("p6_highs", h, 15);
    check("p6_rdylo", rl, 14);
    run_period(0, 1, 4'hC, 4'hC, 0, h, wr, rl, w0, pc);
    check("p7_pc",    pc, 3);
    check("p7_highs", h, 9);
    check("p7_rdylo", rl, 15);
    run_period(-1, -2, 4'h0, 4'h0, 0, h, wr, rl, w0, pc);
    check("p8_pc",    pc, 0);
    check("p8_highs", h, 12);

    // Count anomalies: jump 5->9, jump 14->0, held 0.
    tick(4'h0);
    check("p9_wrap", wrap, 1);
    for (int c = 1; c <= 5; c++) tick(4'(c));
    check("pre_jump_err", count_err, 0);
    tick(4'h9);
    check("jump_err",  count_err, 32'(EXP_ERR));
    check("jump_wrap", wrap, 0);
    for (int c = 10; c <= 14; c++) tick(4'(c));
    tick(4'h0);
    check("j14to0_wrap", wrap, 0);
    tick(4'h0);
    check("held_wrap", wrap, 0);
    for (int c = 1; c <= 15; c++) tick(4'(c));
    run_period(-1, -2, 4'h0, 4'h0, 0, h, wr, rl, w0, pc);
    check("p10_w0",    w0, 1);
    check("p10_pc",    pc, 2);
    check("p10_highs", h, 12);
    check("sticky_err", count_err, 32'(EXP_ERR));

    // Reset mid-period at count 7 with a pending duty.
    tick(4'h0);
    tick(4'h1);
    tick(4'h2);
    duty_in = 4'h2; duty_valid = 1'b1;
    tick(4'h3);
    duty_valid = 1'b0;
    for (int c = 4; c <= 7; c++) tick(4'(c));
    check("pre_rst_ready", duty_ready, 0);
    check("pre_rst_pwm",   pwm_out, 1);
    check("pre_rst_pc",    period_cnt, 3);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_pwm",   pwm_out, 0);
    check("mid_rst_pc",    period_cnt, 0);
    check("mid_rst_ready", duty_ready, 1);
    check("mid_rst_err",   count_err, 0);
    cyc(); cyc(); cyc();
    check("hold_rst_wrap", wrap, 0);
    reset = 1'b1;

    run_period(-1, -2, 4'h0, 4'h0, 0, h, wr, rl, w0, pc);
    check("post_rst_wraps", wr, 0);
    check("post_rst_err",   count_err, 0);
    run_period(-1, -2, 4'h0, 4'h0, 0, h, wr, rl, w0, pc);
    check("post_rst_pc",    pc, 1);
    check("post_rst_highs", h, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/count_pwm.md
COUNT_PWM -- requirements
Module: count_pwm

Interface
REQ-001 Parameter PERIOD_W, default 8, width of the completed-period counter.
REQ-002 clk  input  1  rising-edge clock shared with the upstream mod-16 counter.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 count  input  4  free-running count value from the upstream mod-16 counter.
REQ-005 duty_in  input  4  requested duty value; high for duty_in of 16 counts.
REQ-006 duty_valid  input  1  duty_in is valid this cycle.
REQ-007 duty_ready  output  1  block can accept duty_in this cycle.
REQ-008 pwm_out  output  1  registered PWM output.
REQ-009 wrap  output  1  one-cycle pulse marking the start of a period (count 15->0).
REQ-010 period_cnt  output  PERIOD_W  number of completed periods, modulo 2^PERIOD_W.
REQ-011 count_err  output  1  sticky flag: count did not advance by exactly +1 mod 16.

Function
REQ-012 Block SHALL register count every cycle into prev_count and set a one-bit prev_vld after the first post-reset sample.
REQ-013 Wrap condition SHALL be: prev_vld=1, prev_count=15 and count=0.
REQ-014 wrap SHALL be asserted for exactly one cycle, on the clock edge where the wrap condition is true, giving 1-cycle latency.
REQ-015 Duty handshake SHALL transfer when duty_valid=1 and duty_ready=1 at a rising edge; duty_in is then stored in the pending register and pending_full is set.
REQ-016 duty_ready SHALL equal NOT pending_full; a transfer SHALL clear duty_ready on the next cycle.
REQ-017 On a wrap edge with pending_full=1, active_duty SHALL load pending, pending_full SHALL clear, and duty_ready SHALL be 1 on the next cycle.
REQ-018 A transfer on the same edge as a wrap SHALL NOT be applied at that wrap; it becomes pending and applies at the following wrap.
REQ-019 pwm_out SHALL be registered as (count < duty_eff), where duty_eff = pending value on a wrap edge with pending_full=1, else active_duty.
REQ-020 Duty 0 SHALL give pwm_out constantly 0; duty 15 SHALL give 15 high cycles per 16.
REQ-021 period_cnt SHALL increment on each wrap edge and roll over from 2^PERIOD_W-1 to 0.
REQ-022 A count jump that is not +1 mod 16 SHALL NOT generate wrap and SHALL NOT change active_duty.
REQ-023 A held count (count = prev_count) SHALL NOT generate wrap.

Reset
REQ-024 While reset=0, all outputs and state SHALL be forced immediately, independent of clk.
REQ-025 Reset values: pwm_out=0, wrap=0, period_cnt=0, count_err=0, duty_ready=1, active_duty=0, pending_full=0, prev_vld=0.
REQ-026 Reset asserted mid-period SHALL discard any pending duty.
REQ-027 After reset release, the first sampled count SHALL NOT produce wrap or count_err.

Configuration
REQ-028 Macro COUNT_PWM_CHECK_EN defined: count_err SHALL set when prev_vld=1 and count != prev_count+1 mod 16, and SHALL clear only on reset.
REQ-029 Macro COUNT_PWM_CHECK_EN undefined: count_err SHALL be tied to 0 and no checker logic SHALL be instantiated; all other behaviour is unchanged.

Verification
REQ-030 Release reset with count free-running from 0 and no duty written -> pwm_out=0 throughout; wrap pulses every 16 cycles; period_cnt increments 0,1,2.
REQ-031 Write duty_in=4 mid-period -> duty_ready=0 until the next wrap; the following period has pwm_out high for exactly 4 cycles (counts 0-3), then duty_ready=1.
REQ-032 Perform the transfer on the same edge as a wrap -> the new duty applies only from the next wrap; the current period keeps the old duty.
REQ-033 Hold duty_valid=1 with duty_in=9 then 12 while pending_full=1 -> only 9 is accepted; 12 is accepted after the wrap and applies one period later.
REQ-034 With COUNT_PWM_CHECK_EN defined, inject count 5->9 -> count_err=1 and stays 1; no wrap occurs. Without the macro -> count_err=0.
REQ-035 Assert reset for 3 cycles at count=7 with pending_full=1 -> all outputs take reset values asynchronously; the pending duty is lost; PERIOD_W=2 wraps period_cnt 3->0.
